// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// A transaction is accepted in IDLE, runs through EXEC, and is returned in RESP.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant, owner;
  logic   grant, grant_any, accept;

  logic [1:0][WIDTH-1:0] a_in, b_in;
  logic [1:0][1:0]       op_in;

  assign a_in  = {req_a1, req_a0};
  assign b_in  = {req_b1, req_b0};
  assign op_in = {req_op1, req_op0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    grant     = 1'b0;
    grant_any = 1'b0;
    req_ready = '0;
    rsp_valid = '0;
    state_nxt = state;
    case (req_valid)
      2'b01:   begin grant = 1'b0;        grant_any = 1'b1; end
      2'b10:   begin grant = 1'b1;        grant_any = 1'b1; end
      2'b11:   begin grant = ~last_grant; grant_any = 1'b1; end
      default: ;
    endcase
    case (state)
      IDLE: begin
        if (grant_any) begin
          req_ready[grant] = 1'b1;
          state_nxt        = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && grant_any;

  // The ALU operand registers double as the latched request, so alu_* only
  // move on an accept and stay put through EXEC and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 2'b00;
      rsp_c      <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        alu_a      <= a_in[grant];
        alu_b      <= b_in[grant];
        alu_op     <= op_in[grant];
        owner      <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        if (alu_op == 2'b11) begin
          rsp_c    <= '0;
          rsp_zero <= 1'b1;
          rsp_err  <= 1'b1;
        end else begin
          rsp_c    <= alu_c;
          rsp_zero <= alu_zero;
          rsp_err  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: timestamped transaction model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]  req_op0 = '0, req_op1 = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [31:0] rsp_c;
  logic        rsp_zero, rsp_err;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [1:0]  alu_op;
  logic        alu_zero;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // External ALU; op 11 returns junk that the arbiter must discard.
  always_comb begin
    alu_c    = '0;
    alu_zero = 1'b0;
    case (alu_op)
      2'b00: alu_c = alu_a + alu_b;
      2'b01: alu_c = alu_a - alu_b;
      2'b10: alu_c = alu_a | alu_b;
      default: alu_c = alu_a ^ alu_b ^ 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_op != 2'b11) && (alu_c == 32'd0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // Expected {c, zero, err} straight from the operation rules.
  function automatic logic [33:0] ref_op(input logic [31:0] a, b, input logic [1:0] op);
    logic [31:0] c;
    case (op)
      2'b00:   c = a + b;
      2'b01:   c = a - b;
      2'b10:   c = a | b;
      default: c = 32'd0;
    endcase
    return {c, (op == 2'b11) || (c == 32'd0), op == 2'b11};
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  initial begin
    int          cyc_n = 0;
    bit          m_pend = 0, m_own = 0, m_last = 1;
    int          m_acc = 0;
    logic [31:0] e_a = '0, e_b = '0, e_c = '0;
    logic [1:0]  e_op = '0;
    logic        e_z = 1'b0, e_e = 1'b0;
    logic [33:0] r_res = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pend = 0; m_last = 1;
        e_a = '0; e_b = '0; e_op = '0; e_c = '0; e_z = 1'b0; e_e = 1'b0;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_c", rsp_c, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_op", alu_op, 0);
      end else begin
        int g;
        logic [1:0] er, ev;
        g = -1;
        if (!m_pend) begin
          if (req_valid == 2'b01) g = 0;
          else if (req_valid == 2'b10) g = 1;
          else if (req_valid == 2'b11) g = m_last ? 0 : 1;
        end
        er = (g < 0) ? 2'b00 : 2'(1 << g);
        ev = (m_pend && cyc_n >= m_acc + 2) ? 2'(1 << m_own) : 2'b00;
        chk("m_req_ready", req_ready, er);
        chk("m_rsp_valid", rsp_valid, ev);
        chk("m_alu_a", alu_a, e_a);
        chk("m_alu_b", alu_b, e_b);
        chk("m_alu_op", alu_op, e_op);
        chk("m_rsp_c", rsp_c, e_c);
        chk("m_rsp_zero", rsp_zero, e_z);
        chk("m_rsp_err", rsp_err, e_e);
        if (m_pend && cyc_n == m_acc + 1) begin
          e_c = r_res[33:2]; e_z = r_res[1]; e_e = r_res[0];
        end
        if (m_pend && cyc_n >= m_acc + 2 && rsp_ready[m_own]) m_pend = 0;
        if (g >= 0) begin
          m_pend = 1; m_acc = cyc_n; m_own = g[0]; m_last = g[0];
          e_a  = g[0] ? req_a1 : req_a0;
          e_b  = g[0] ? req_b1 : req_b0;
          e_op = g[0] ? req_op1 : req_op0;
          r_res = ref_op(e_a, e_b, e_op);
        end
      end
      cyc_n++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, b, input logic [1:0] op);
    if (i == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
    else        begin req_a1 = a; req_b1 = b; req_op1 = op; end
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    while (!req_ready[i] && n < 20) begin cyc(); n++; end
    if (!req_ready[i]) timeout("wait_ready");
  endtask

  task automatic wait_rsp(input int i);
    int n = 0;
    while (!rsp_valid[i] && n < 20) begin cyc(); n++; end
    if (!rsp_valid[i]) timeout("wait_rsp");
  endtask

  task automatic do_req(input int i, input logic [31:0] a, b, input logic [1:0] op,
                        output logic [31:0] c, output logic z, e, output logic [1:0] v);
    set_req(i, a, b, op);
    #1;
    wait_ready(i);
    cyc();
    req_valid[i] = 1'b0;
    wait_rsp(i);
    c = rsp_c; z = rsp_zero; e = rsp_err; v = rsp_valid;
    cyc();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] c;
    logic        z, e;
    logic [1:0]  v, acc;
    int          gq[$];
    int          gc[$];

    #1 rst_n = 1'b0;
    repeat (3) cyc();
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_c", rsp_c, 0);
    chk("reset_flags", {rsp_zero, rsp_err}, 0);
    chk("reset_alu", {alu_a, alu_b}, 0);
    rst_n = 1'b1;
    cyc();

    // Single request, exact latency.
    set_req(0, 32'd5, 32'd3, 2'b00);
    #1 chk("t1_ready", req_ready, 2'b01);
    cyc();
    req_valid = '0;
    chk("t1_alu_op", alu_op, 2'b00);
    chk("t1_alu_a", alu_a, 5);
    chk("t1_alu_b", alu_b, 3);
    chk("t1_no_rsp_yet", rsp_valid, 0);
    cyc();
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_c", rsp_c, 8);
    chk("t1_rsp_zero", rsp_zero, 0);
    cyc();

    // Subtract to zero and wrap-around.
    do_req(1, 32'd7, 32'd7, 2'b01, c, z, e, v);
    chk("sub_zero_valid", v, 2'b10);
    chk("sub_zero_c", c, 0);
    chk("sub_zero_z", z, 1);
    do_req(1, 32'd0, 32'd1, 2'b01, c, z, e, v);
    chk("sub_wrap_c", c, 32'hFFFF_FFFF);
    chk("sub_wrap_z", z, 0);

    // Contention: both continuously valid, grants alternate 3 cycles apart.
    set_req(0, 32'd1, 32'd1, 2'b00);
    set_req(1, 32'd12, 32'd3, 2'b10);
    #1;
    for (int k = 0; k < 12; k++) begin
      if (req_ready != 2'b00) begin gq.push_back(int'(req_ready[1])); gc.push_back(k); end
      if (rsp_valid == 2'b01) chk("cont_c0", rsp_c, 2);
      else if (rsp_valid == 2'b10) chk("cont_c1", rsp_c, 15);
      cyc();
    end
    req_valid = '0;
    chk("cont_grants", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
      chk("cont_order", gq[i], i % 2);
      if (i > 0) chk("cont_spacing", gc[i] - gc[i-1], 3);
    end
    repeat (2) cyc();

    // Backpressure on owner 0 while requester 1 waits.
    rsp_ready = 2'b00;
    set_req(0, 32'd1, 32'd2, 2'b00);
    set_req(1, 32'd5, 32'd5, 2'b01);
    #1;
    wait_ready(0);
    cyc();
    req_valid[0] = 1'b0;
    wait_rsp(0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", rsp_valid, 2'b01);
      chk("bp_c", rsp_c, 3);
      chk("bp_zero", rsp_zero, 0);
      chk("bp_req1_blocked", req_ready, 0);
      cyc();
    end
    rsp_ready = 2'b11;
    cyc();
    chk("bp_req1_after", req_ready, 2'b10);
    cyc();
    req_valid[1] = 1'b0;
    wait_rsp(1);
    chk("bp_req1_c", rsp_c, 0);
    chk("bp_req1_z", rsp_zero, 1);
    cyc();

    // Illegal op then legal op.
    do_req(0, 32'd9, 32'd4, 2'b11, c, z, e, v);
    chk("ill_err", e, 1);
    chk("ill_c", c, 0);
    chk("ill_z", z, 1);
    do_req(0, 32'd2, 32'd3, 2'b00, c, z, e, v);
    chk("legal_err", e, 0);
    chk("legal_c", c, 5);

    // Async reset during RESP.
    rsp_ready = 2'b00;
    set_req(1, 32'd3, 32'd4, 2'b00);
    #1;
    wait_ready(1);
    cyc();
    req_valid[1] = 1'b0;
    wait_rsp(1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_c", rsp_c, 0);
    chk("arst_alu_a", alu_a, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 2'b11;
    set_req(0, 32'd10, 32'd1, 2'b01);
    set_req(1, 32'd1, 32'd1, 2'b00);
    #1 chk("arst_first_grant", req_ready, 2'b01);
    cyc();
    req_valid[0] = 1'b0;
    wait_rsp(0);
    chk("arst_c0", rsp_c, 9);
    cyc();
    wait_ready(1);
    cyc();
    req_valid[1] = 1'b0;
    wait_rsp(1);
    chk("arst_c1", rsp_c, 2);
    cyc();

    // Random traffic; requesters hold valid and operands until accepted.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || !req_valid[i]) begin
          if ($urandom_range(0, 2) != 0)
            set_req(i, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom,
                       ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom,
                       2'($urandom_range(0, 3)));
          else
            req_valid[i] = 1'b0;
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU (ops: 00 add, 01 sub, 10 or) between two requesters, e.g. the execute stage and the branch-compare unit of the multi-cycle core.
- Arbitrates with round-robin priority, drives the ALU operands and op, registers the result and Zero flag, and returns them to the winner over a valid/ready handshake.
- Sits between the requesters and the ALU instance; the ALU itself is outside this block.

Parameters:
- WIDTH, 32, operand and result width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid[1:0]  input  2  per-requester request valid.
- req_ready[1:0]  output  2  per-requester request accepted this cycle.
- req_a0, req_b0  input  WIDTH  requester 0 operands.
- req_a1, req_b1  input  WIDTH  requester 1 operands.
- req_op0, req_op1  input  2  requester op codes.
- rsp_valid[1:0]  output  2  per-requester response valid.
- rsp_ready[1:0]  input  2  per-requester response taken.
- rsp_c  output  WIDTH  registered result, shared by both requesters.
- rsp_zero  output  1  registered Zero flag.
- rsp_err  output  1  set when the op was 2'b11 (illegal).
- alu_a, alu_b  output  WIDTH  ALU operands.
- alu_op  output  2  ALU op.
- alu_c  input  WIDTH  ALU result.
- alu_zero  input  1  ALU Zero flag.

Behaviour:
- Reset (async, rst_n low): state=IDLE, last_grant=1 (so requester 0 wins the first tie), req_ready=0, rsp_valid=0, rsp_c=0, rsp_zero=0, rsp_err=0, alu_a=0, alu_b=0, alu_op=00; latched operands and owner cleared.
- States: IDLE, EXEC, RESP.
- IDLE grant (combinational):
  - Only one valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - req_ready[g]=1 only in IDLE, only for the granted requester, and only when its req_valid is high; never both bits high.
- Accept = req_valid[g] & req_ready[g]:
  - Latch a, b, op and owner=g; set last_grant=g.
  - Next state is EXEC.
- EXEC (1 cycle):
  - alu_a/alu_b/alu_op are driven from the latched registers, stable for the whole cycle.
  - At the clock edge, capture rsp_c=alu_c and rsp_zero=alu_zero.
  - Op 2'b11: the ALU result is ignored; capture rsp_c=0, rsp_zero=1, rsp_err=1. Otherwise rsp_err=0.
  - Next state is RESP.
- RESP:
  - rsp_valid[owner]=1; the other bit is 0.
  - rsp_c, rsp_zero and rsp_err hold stable until rsp_ready[owner]=1.
  - rsp_ready of the non-owner is ignored.
  - Handshake completes -> IDLE.
- Throughput and latency:
  - Accept at cycle N -> rsp_valid at N+2.
  - Minimum 3 cycles per operation; the next accept is possible in the cycle after the response handshake.
- Outside EXEC, alu_* hold their last value (no glitching toggles).
- Requests asserted during EXEC/RESP wait with ready=0. Requesters hold valid and operands until ready.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Reset mid-operation (EXEC or RESP): the operation is abandoned, no response is issued, and all outputs take their reset values immediately.
- Arithmetic is WIDTH bits, modulo 2^WIDTH, with no overflow flag; Zero comes from the ALU.

Test Plan:
- Reset then single request: req0 a=5, b=3, op=00 at cycle 1 -> ready0=1 at cycle 1, alu_op=00 at cycle 2, rsp_valid=01 at cycle 3 with rsp_c=8, rsp_zero=0.
- Sub to zero: req1 a=7, b=7, op=01 -> rsp_valid=10, rsp_c=0, rsp_zero=1; a=0, b=1, op=01 -> rsp_c=32'hFFFFFFFF.
- Contention: both valid continuously with distinct ops (req0 a=1,b=1,op=00; req1 a=12,b=3,op=10) -> grant order 0,1,0,1; responses 2 and 15 to the correct owners, each accept 3 cycles apart.
- Backpressure: hold rsp_ready0=0 for 5 cycles -> rsp_valid0, rsp_c and rsp_zero stable throughout; req1 ready stays 0 until the handshake completes.
- Illegal op: req0 op=11, a=9 -> rsp_err=1, rsp_c=0, rsp_zero=1; the next legal op gives rsp_err=0.
- Async reset: assert rst_n=0 mid-cycle during RESP -> rsp_valid=0 and state=IDLE without a clock edge; after release, req1 and req0 both valid -> req0 granted first.
